// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source with frame-synchronous mode switching.
// Two registered stages from pixel position to RGB, black during blanking.
module vga_pattern_gen #(
  parameter int WIDTH       = 800,
  parameter int HEIGHT      = 480,
  parameter int XBITS       = 11,
  parameter int YBITS       = 10,
  parameter int CBITS       = 8,
  parameter int GRAD_XSHIFT = 2,
  parameter int GRAD_YSHIFT = 1,
  parameter int CHECK_LOG2  = 5,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 4
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [XBITS-1:0]   fb_xpos,
  input  logic [YBITS-1:0]   fb_ypos,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [2:0]         mode_sel,
  input  logic [3*CBITS-1:0] solid_rgb,
  output logic [CBITS-1:0]   red,
  output logic [CBITS-1:0]   green,
  output logic [CBITS-1:0]   blue,
  output logic               out_valid,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [2:0] {
    M_GRAD, M_BARS, M_CHECK, M_SOLID,
    M_BOX, M_SCROLL, M_BLK6, M_BLK7
  } mode_t;

  localparam int BAR_W = WIDTH / 8;
  localparam logic [XBITS-1:0] BAR_LAST = XBITS'(BAR_W - 1);
  localparam logic [XBITS:0] X_STEP = (XBITS+1)'(BOX_STEP);
  localparam logic [XBITS:0] X_MAX  = (XBITS+1)'(WIDTH - BOX_SIZE);
  localparam logic [XBITS:0] X_SIZE = (XBITS+1)'(BOX_SIZE);
  localparam logic [YBITS:0] Y_STEP = (YBITS+1)'(BOX_STEP);
  localparam logic [YBITS:0] Y_MAX  = (YBITS+1)'(HEIGHT - BOX_SIZE);
  localparam logic [YBITS:0] Y_SIZE = (YBITS+1)'(BOX_SIZE);

  mode_t              mode_q;
  logic [3*CBITS-1:0] solid_q;
  logic [XBITS-1:0]   box_x, box_x_nxt;
  logic [YBITS-1:0]   box_y, box_y_nxt;
  logic               dir_x, dir_x_nxt;
  logic               dir_y, dir_y_nxt;
  logic [XBITS-1:0]   bar_cnt, cnt_eff, cnt_nxt;
  logic [2:0]         bar_idx, idx_eff, idx_nxt;
  logic               bar_first;
  logic [XBITS:0]     xw, bx_sum;
  logic [YBITS:0]     yw, by_sum;
  logic [CBITS-1:0]   grad_r, grad_b;
  logic               in_box, chk;
  logic [3*CBITS-1:0] color;
  logic               v1;
  logic [3*CBITS-1:0] c1;

  // Bar counters: a pixel at x==0 restarts the line at bar 0
  always_comb begin
    bar_first = pix_valid && (fb_xpos == '0);
    cnt_eff   = bar_first ? '0 : bar_cnt;
    idx_eff   = bar_first ? 3'd0 : bar_idx;
    cnt_nxt   = cnt_eff + 1'b1;
    idx_nxt   = idx_eff;
    if (cnt_eff == BAR_LAST) begin
      cnt_nxt = '0;
      if (idx_eff != 3'd7) idx_nxt = idx_eff + 3'd1;
    end
  end

  // Box bounce: clamp to the edge and reverse direction
  always_comb begin
    bx_sum    = {1'b0, box_x} + X_STEP;
    by_sum    = {1'b0, box_y} + Y_STEP;
    box_x_nxt = bx_sum[XBITS-1:0];
    box_y_nxt = by_sum[YBITS-1:0];
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    if (!dir_x) begin
      if (bx_sum >= X_MAX) begin
        box_x_nxt = X_MAX[XBITS-1:0];
        dir_x_nxt = 1'b1;
      end
    end else if ({1'b0, box_x} <= X_STEP) begin
      box_x_nxt = '0;
      dir_x_nxt = 1'b0;
    end else begin
      box_x_nxt = box_x - X_STEP[XBITS-1:0];
    end
    if (!dir_y) begin
      if (by_sum >= Y_MAX) begin
        box_y_nxt = Y_MAX[YBITS-1:0];
        dir_y_nxt = 1'b1;
      end
    end else if ({1'b0, box_y} <= Y_STEP) begin
      box_y_nxt = '0;
      dir_y_nxt = 1'b0;
    end else begin
      box_y_nxt = box_y - Y_STEP[YBITS-1:0];
    end
  end

  // Pattern colour for the current pixel under the latched mode
  always_comb begin
    xw     = {1'b0, fb_xpos};
    yw     = {1'b0, fb_ypos};
    grad_r = CBITS'(xw >> GRAD_XSHIFT);
    grad_b = CBITS'(yw >> GRAD_YSHIFT);
    in_box = (xw >= {1'b0, box_x})
          && (xw < {1'b0, box_x} + X_SIZE)
          && (yw >= {1'b0, box_y})
          && (yw < {1'b0, box_y} + Y_SIZE);
    chk    = fb_xpos[CHECK_LOG2] ^ fb_ypos[CHECK_LOG2];
    color  = '0;
    unique case (mode_q)
      M_GRAD:   color = {grad_r, {CBITS{1'b0}}, grad_b};
      M_BARS:   color = {{CBITS{~idx_eff[1]}},
                         {CBITS{~idx_eff[2]}},
                         {CBITS{~idx_eff[0]}}};
      M_CHECK:  color = {(3*CBITS){chk}};
      M_SOLID:  color = solid_q;
      M_BOX:    color = in_box ? {(3*CBITS){1'b1}} : solid_q;
      M_SCROLL: color = {grad_r + frame_cnt[CBITS-1:0],
                         {CBITS{1'b0}}, grad_b};
      default:  color = '0;
    endcase
  end

  // Frame-synchronous state: mode, colour, frame count, box
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= M_GRAD;
      solid_q   <= '0;
      frame_cnt <= '0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
    end else if (frame_start) begin
      mode_q    <= mode_t'(mode_sel);
      solid_q   <= solid_rgb;
      frame_cnt <= frame_cnt + 16'd1;
      box_x     <= box_x_nxt;
      box_y     <= box_y_nxt;
      dir_x     <= dir_x_nxt;
      dir_y     <= dir_y_nxt;
    end
  end

  // Bar counters advance on active pixels only
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_valid) begin
      bar_cnt <= cnt_nxt;
      bar_idx <= idx_nxt;
    end
  end

  // Two-stage pipeline, black whenever the pixel is not valid
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      c1        <= '0;
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      v1        <= pix_valid;
      c1        <= pix_valid ? color : '0;
      out_valid <= v1;
      {red, green, blue} <= v1 ? c1 : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: modes, frame sync, box, reset.
// Expected colours are hand-derived; box position uses a small model.
module tb_vga_pattern_gen;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] fb_xpos = '0;
  logic [9:0]  fb_ypos = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  mode_sel = '0;
  logic [23:0] solid_rgb = '0;
  logic [7:0]  red, green, blue;
  logic        out_valid;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int fcnt = 0;
  int bx = 0, by = 0;
  bit dx = 0, dy = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_pattern_gen dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .fb_xpos(fb_xpos), .fb_ypos(fb_ypos),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic model_frame();
    fcnt = (fcnt + 1) & 16'hFFFF;
    if (!dx) begin
      if (bx + 4 >= 736) begin bx = 736; dx = 1; end
      else bx = bx + 4;
    end else begin
      if (bx <= 4) begin bx = 0; dx = 0; end
      else bx = bx - 4;
    end
    if (!dy) begin
      if (by + 4 >= 416) begin by = 416; dy = 1; end
      else by = by + 4;
    end else begin
      if (by <= 4) begin by = 0; dy = 0; end
      else by = by - 4;
    end
  endtask

  task automatic frame();
    @(negedge vga_clk);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    model_frame();
  endtask

  task automatic probe(input int x, input int y,
                       input logic v, input logic fs,
                       input logic [23:0] exp,
                       input logic expv, input string tag);
    @(negedge vga_clk);
    fb_xpos = 11'(x);
    fb_ypos = 10'(y);
    pix_valid = v;
    frame_start = fs;
    @(negedge vga_clk);
    pix_valid = 1'b0;
    frame_start = 1'b0;
    if (fs) model_frame();
    @(negedge vga_clk);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp));
    check({tag, "_vld"}, 32'(out_valid), 32'(expv));
  endtask

  initial begin
    repeat (2) @(negedge vga_clk);
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_vld", 32'(out_valid), 32'h0);
    check("rst_fcnt", 32'(frame_cnt), 32'h0);
    reset_n = 1'b1;

    mode_sel = 3'd0;
    frame();
    check("fcnt1", 32'(frame_cnt), 32'(fcnt));
    probe(400, 200, 1, 0, 24'h640064, 1, "grad");
    probe(799, 479, 1, 0, 24'hC700EF, 1, "grad_max");

    mode_sel = 3'd1;
    frame();
    for (int i = 0; i < 802; i++) begin
      @(negedge vga_clk);
      if (i >= 2) begin
        check("bars_rgb", 32'({red, green, blue}),
              32'(bars[(i - 2) / 100]));
        check("bars_vld", 32'(out_valid), 32'h1);
      end
      fb_xpos = 11'(i);
      fb_ypos = 10'd7;
      pix_valid = (i < 800);
    end

    mode_sel = 3'd2;
    frame();
    probe(31, 0, 1, 0, 24'h000000, 1, "chk_31_0");
    probe(32, 0, 1, 0, 24'hFFFFFF, 1, "chk_32_0");
    probe(32, 32, 1, 0, 24'h000000, 1, "chk_32_32");
    probe(0, 32, 1, 0, 24'hFFFFFF, 1, "chk_0_32");

    mode_sel = 3'd3;
    solid_rgb = 24'h123456;
    frame();
    probe(400, 200, 1, 0, 24'h123456, 1, "solid");
    mode_sel = 3'd0;
    solid_rgb = 24'hAAAAAA;
    probe(400, 200, 1, 0, 24'h123456, 1, "midframe");
    probe(400, 200, 1, 1, 24'h123456, 1, "fs_coinc");
    probe(400, 200, 1, 0, 24'h640064, 1, "after_fs");

    mode_sel = 3'd3;
    solid_rgb = 24'hFFFFFF;
    frame();
    probe(10, 10, 0, 0, 24'h000000, 0, "blank");
    probe(10, 10, 1, 0, 24'hFFFFFF, 1, "unblank");

    mode_sel = 3'd5;
    frame();
    check("fcnt_s", 32'(frame_cnt), 32'(fcnt));
    probe(400, 200, 1, 0, {8'(100 + fcnt), 8'h00, 8'h64}, 1, "scroll");
    probe(0, 0, 1, 0, {8'(fcnt), 8'h00, 8'h00}, 1, "scroll0");

    mode_sel = 3'd6;
    frame();
    probe(400, 200, 1, 0, 24'h000000, 1, "mode6");
    mode_sel = 3'd7;
    frame();
    probe(400, 200, 1, 0, 24'h000000, 1, "mode7");

    mode_sel = 3'd3;
    solid_rgb = 24'hFFFFFF;
    frame();
    @(negedge vga_clk);
    fb_xpos = 11'd5; fb_ypos = 10'd3; pix_valid = 1'b1;
    @(negedge vga_clk);
    fb_xpos = 11'd6;
    @(negedge vga_clk);
    fb_xpos = 11'd7;
    check("pre_rst_rgb", 32'({red, green, blue}), 32'hFFFFFF);
    check("pre_rst_vld", 32'(out_valid), 32'h1);
    @(posedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
    check("mid_rst_vld", 32'(out_valid), 32'h0);
    check("mid_rst_fcnt", 32'(frame_cnt), 32'h0);
    fcnt = 0; bx = 0; by = 0; dx = 0; dy = 0;
    @(negedge vga_clk);
    pix_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge vga_clk);
    check("post_rst_rgb", 32'({red, green, blue}), 32'h0);
    check("post_rst_vld", 32'(out_valid), 32'h0);
    probe(10, 10, 1, 0, 24'h020005, 1, "post_rst");

    mode_sel = 3'd4;
    solid_rgb = 24'h000080;
    for (int f = 0; f < 200; f++) begin
      frame();
      probe(bx, by, 1, 0, 24'hFFFFFF, 1, "box_tl");
      probe(bx + 63, by + 63, 1, 0, 24'hFFFFFF, 1, "box_br");
      if (bx > 0)
        probe(bx - 1, by, 1, 0, 24'h000080, 1, "box_left");
      if (bx + 64 < 800)
        probe(bx + 64, by, 1, 0, 24'h000080, 1, "box_right");
      if (by + 64 < 480)
        probe(bx, by + 64, 1, 0, 24'h000080, 1, "box_below");
    end
    probe(799, 479, 1, 0, 24'h000080, 1, "box_far");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised multi-mode test-pattern source for the VGA output path, driven by the pixel position from the VGA timing generator. It replaces the fixed gradient pattern. It adds selectable patterns, frame-synchronous mode switching, animated content, blanking-aware output and a registered 2-stage pipeline. Its RGB outputs feed the VGA DAC / LCD interface directly.

Parameters:
WIDTH, 800, active pixels per line
HEIGHT, 480, active lines per frame
XBITS, 11, width of fb_xpos
YBITS, 10, width of fb_ypos
CBITS, 8, bits per colour channel
GRAD_XSHIFT, 2, right-shift applied to x for gradient red
GRAD_YSHIFT, 1, right-shift applied to y for gradient blue
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
BOX_SIZE, 64, moving-box edge length in pixels
BOX_STEP, 4, box displacement per frame, per axis

Ports:
vga_clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
fb_xpos  in  XBITS  current pixel column
fb_ypos  in  YBITS  current pixel row
pix_valid  in  1  high while (fb_xpos, fb_ypos) is inside the active area
frame_start  in  1  one-cycle pulse, once per frame, during vertical blanking
mode_sel  in  3  requested pattern mode
solid_rgb  in  3*CBITS  {R,G,B} colour for solid and box-background modes
red/green/blue  out  CBITS each  registered pixel colour
out_valid  out  1  pix_valid delayed to align with RGB
frame_cnt  out  16  frames since reset

Behaviour:
- Reset is asynchronous on reset_n low. Clocking is on the vga_clk rising edge.
- Reset values: red/green/blue = 0, out_valid = 0, frame_cnt = 0, mode_q = 0, solid_q = 0, box_x = box_y = 0, box direction = +x/+y, bar_idx = 0, bar_cnt = 0, pipeline valids = 0.
- Latency is exactly 2 cycles from the inputs to red/green/blue/out_valid.
  - Stage 1 registers the pattern colour and valid.
  - Stage 2 registers the outputs.
- Blanking: when the stage-2 valid is 0, outputs are forced to 0 (black).
- frame_start handling, all applied on the same edge:
  - frame_cnt += 1, wrapping 0xFFFF -> 0.
  - mode_q <= mode_sel and solid_q <= solid_rgb.
  - The box position updates.
  - The new values take effect from the next cycle. A pixel presented in the frame_start cycle uses the old values.
- mode_sel and solid_rgb changes mid-frame have no visible effect until the next frame_start.
- Modes (mode_q):
  - 0, gradient: R = (x >> GRAD_XSHIFT) truncated to the low CBITS; G = 0; B = (y >> GRAD_YSHIFT) truncated to the low CBITS.
  - 1, colour bars: 8 vertical bars, BAR_W = WIDTH/8 (integer).
    - Order: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or 0.
    - The bar index comes from counters, with no divider. bar_cnt/bar_idx reset when pix_valid && fb_xpos == 0.
    - Otherwise, on each pix_valid cycle, bar_cnt increments. At BAR_W-1 it clears and bar_idx increments.
    - bar_idx saturates at 7, so remainder pixels when WIDTH is not divisible by 8 stay black.
  - 2, checkerboard: white if x[CHECK_LOG2] XOR y[CHECK_LOG2] is 1, else black.
  - 3, solid: RGB = solid_q.
  - 4, moving box:
    - White if box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE; otherwise solid_q.
    - Per frame_start, x axis moving +: if box_x + BOX_STEP >= WIDTH-BOX_SIZE, then box_x = WIDTH-BOX_SIZE and direction flips to −. Otherwise box_x += BOX_STEP.
    - x axis moving −: if box_x <= BOX_STEP, then box_x = 0 and direction flips to +. Otherwise box_x -= BOX_STEP.
    - The y axis follows the same rules with HEIGHT.
  - 5, scrolling gradient: as mode 0, but R = ((x >> GRAD_XSHIFT) + frame_cnt[CBITS-1:0]) mod 2^CBITS.
  - 6, 7: black.
- Box motion runs in every mode, not only mode 4.
- Internal compare/sum widths are wide enough for no overflow before truncation (XBITS+1 / YBITS+1).
- Reset mid-frame: outputs go to 0 immediately (async). After release, the output is blank until pix_valid propagates through both stages.

Test Plan:
- Reset, then mode_sel=0, frame_start, pixel (x=400, y=200, valid) -> 2 cycles later R=100, G=0, B=100, out_valid=1.
- Mode 1, full line x=0..799 -> x=0..99 white (FF,FF,FF); x=100 yellow (FF,FF,00); x=700..799 black; colour change lands exactly 2 cycles after the x=100 input.
- Mode 2 with CHECK_LOG2=5: (31,0) white? no, black; (32,0) white; (32,32) black.
- mode_sel changed 3→0 mid-frame -> output stays solid_q until the cycle after the next frame_start; frame_start coincident with a valid pixel -> that pixel uses the old mode.
- Mode 4, 200 frame_start pulses -> box_x sequence 0, 4, …, 736, then 732, …; box_x never exceeds 736 and box_y never exceeds 416; inside the box is white, outside is solid_q.
- pix_valid=0 with mode 3 and solid_rgb=FFFFFF -> RGB=0, out_valid=0. Assert reset_n mid-line -> all outputs 0 in the same cycle; frame_cnt=0.
